instr_fetch: RTL

//  IF stage: fetches 32-bit instructions over the request/grant/rvalid instruction bus.

---
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches on a req/gnt/rvalid bus, buffers the
// responses in a small prefetch FIFO and presents the head entry to decode.
module instr_fetch #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ready_id,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_rdata,
    input  logic        instr_err,
    output logic        instr_value,
    output logic [31:0] instr_payload,
    output logic [31:0] pc_id,
    output logic        instr_fetch_error
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LastIdx = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DepthW  = (CW + 1)'(FIFO_DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastIdx) ? '0 : p + PW'(1);
    endfunction

    logic          active_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          pending_q, pending_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    // Pending request was presented before a redirect: its response must be dropped.
    logic          stale_q, stale_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
    logic [PW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;

    logic [31:0]   aq_mem_q  [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q [FIFO_DEPTH];
    logic [31:0]   fifo_dat_q[FIFO_DEPTH];
    logic          fifo_err_q[FIFO_DEPTH];

    logic credit_ok, issue, resp, drop, push, pop;
    logic unused_rpc;

    assign unused_rpc  = ^redirect_pc[1:0];
    assign credit_ok   = ({1'b0, count_q} + {1'b0, outst_q}) < DepthW;
    assign instr_req   = active_q & (pending_q | credit_ok);
    assign instr_addr  = pending_q ? pend_addr_q : fetch_pc_q;
    assign issue       = instr_req & instr_gnt;
    // Responses with nothing outstanding (e.g. after a reset) are ignored.
    assign resp        = instr_rvalid & (outst_q != '0);
    assign drop        = resp & (discard_q != '0);
    assign push        = resp & ~drop & ~redirect;
    assign instr_value = (count_q != '0);
    assign pop         = instr_value & ready_id & ~redirect;

    assign instr_payload     = fifo_dat_q[f_rd_q];
    assign pc_id             = fifo_pc_q[f_rd_q];
    assign instr_fetch_error = fifo_err_q[f_rd_q];

    // Next-state for fetch address, bus bookkeeping and FIFO pointers.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pending_d   = instr_req & ~instr_gnt;
        pend_addr_d = instr_addr;
        stale_d     = pending_d & (stale_q | redirect);
        outst_d     = outst_q;
        discard_d   = discard_q;
        count_d     = count_q;
        f_rd_d      = f_rd_q;
        f_wr_d      = f_wr_q;
        aq_rd_d     = aq_rd_q;
        aq_wr_d     = aq_wr_q;

        if (issue && !stale_q) fetch_pc_d = instr_addr + 32'd4;
        if (redirect)          fetch_pc_d = {redirect_pc[31:2], 2'b00};

        case ({issue, resp})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect) begin
            discard_d = outst_d;
        end else begin
            if (drop)            discard_d = discard_d - CW'(1);
            if (issue && stale_q) discard_d = discard_d + CW'(1);
        end

        if (issue) aq_wr_d = ptr_inc(aq_wr_q);
        if (resp)  aq_rd_d = ptr_inc(aq_rd_q);

        if (redirect) begin
            f_rd_d  = '0;
            f_wr_d  = '0;
            count_d = '0;
        end else begin
            if (push) f_wr_d = ptr_inc(f_wr_q);
            if (pop)  f_rd_d = ptr_inc(f_rd_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q    <= 1'b0;
            fetch_pc_q  <= BOOT_ADDR;
            pending_q   <= 1'b0;
            pend_addr_q <= BOOT_ADDR;
            stale_q     <= 1'b0;
            outst_q     <= '0;
            discard_q   <= '0;
            count_q     <= '0;
            f_rd_q      <= '0;
            f_wr_q      <= '0;
            aq_rd_q     <= '0;
            aq_wr_q     <= '0;
        end else begin
            active_q    <= 1'b1;
            fetch_pc_q  <= fetch_pc_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            stale_q     <= stale_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            f_rd_q      <= f_rd_d;
            f_wr_q      <= f_wr_d;
            aq_rd_q     <= aq_rd_d;
            aq_wr_q     <= aq_wr_d;
        end
    end

    // Granted-address queue and prefetch storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                aq_mem_q[i]   <= '0;
                fifo_pc_q[i]  <= '0;
                fifo_dat_q[i] <= '0;
                fifo_err_q[i] <= 1'b0;
            end
        end else begin
            if (issue) aq_mem_q[aq_wr_q] <= instr_addr;
            if (push) begin
                fifo_pc_q[f_wr_q]  <= aq_mem_q[aq_rd_q];
                fifo_dat_q[f_wr_q] <= instr_rdata;
                fifo_err_q[f_wr_q] <= instr_err;
            end
        end
    end

endmodule
